// File: rtl/rst_checker_pkg.sv
// Shared types and helpers for the reset-strategy lane checker.
// The top module and the per-lane compare block both import this package.
package rst_checker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WARM  = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam int LANES_DEF = 3;
    localparam int DW_DEF    = 4;
    localparam int CW_DEF    = 8;

    // Extracts lane k (w bits wide) from a flattened lane bus; w must be <= 32.
    function automatic logic [31:0] lane_slice(input logic [1023:0] bus,
                                               input int unsigned   k,
                                               input int unsigned   w);
        logic [1023:0] sh;
        logic [31:0]   mask;
        sh   = bus >> (k * w);
        mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return sh[31:0] & mask;
    endfunction

endpackage

// File: rtl/rst_checker_lane.sv
// One non-golden lane: compares against lane 0 and keeps a sticky flag
// plus a saturating mismatch counter.
module rst_checker_lane
    import rst_checker_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          check,
    input  logic          v_ref,
    input  logic          v_lane,
    input  logic [DW-1:0] d_ref,
    input  logic [DW-1:0] d_lane,
    output logic          mism,
    output logic          err,
    output logic [CW-1:0] cnt
);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
        return (&x) ? x : x + 1'b1;
    endfunction

    // Data only matters when both lanes claim a valid beat.
    assign mism = (v_lane != v_ref) || (v_lane && v_ref && (d_lane != d_ref));

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
            cnt <= '0;
        end else if (clr) begin
            err <= 1'b0;
            cnt <= '0;
        end else if (check && mism) begin
            err <= 1'b1;
            cnt <= sat_inc(cnt);
        end
    end

endmodule

// File: rtl/rst_checker.sv
// Golden-lane checker: lane 0 is the reference, lanes 1..LANES-1 are compared
// against it after a warm-up window; first divergence is captured once.
module rst_checker
    import rst_checker_pkg::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int DW     = DW_DEF,
    parameter int WARMUP = 4,
    parameter int CW     = CW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en_i,
    input  logic                clr_i,
    input  logic [LANES-1:0]    valid_i,
    input  logic [LANES*DW-1:0] data_i,
    output logic                armed_o,
    output logic [LANES-1:0]    err_o,
    output logic [LANES*CW-1:0] err_cnt_o,
    output logic [15:0]         cyc_o,
    output logic                first_vld_o,
    output logic [LANES-1:0]    first_mask_o,
    output logic [15:0]         first_cyc_o
);

    localparam int WCW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam logic [WCW-1:0] WLOAD = (WARMUP > 0) ? WCW'(WARMUP - 1) : '0;

    function automatic logic [15:0] sat_inc16(input logic [15:0] x);
        return (&x) ? x : x + 16'd1;
    endfunction

    logic [LANES-1:0]    v_p0;
    logic [LANES*DW-1:0] d_p0;
    logic [DW-1:0]       d_ref;
    logic [LANES-1:0]    mism;
    logic                check;
    state_t              state, state_nx;
    logic [WCW-1:0]      wcnt, wcnt_nx;

    // Stage p0: unconditional input capture; all compares work on these.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_p0 <= '0;
            d_p0 <= '0;
        end else begin
            v_p0 <= valid_i;
            d_p0 <= data_i;
        end
    end

    assign d_ref   = DW'(lane_slice(1024'(d_p0), 0, DW));
    assign check   = (state == CHECK);
    assign armed_o = check;

    assign mism[0]           = 1'b0;
    assign err_o[0]          = 1'b0;
    assign err_cnt_o[CW-1:0] = '0;

    for (genvar k = 1; k < LANES; k++) begin : g_lane
        rst_checker_lane #(
            .DW(DW),
            .CW(CW)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .clr    (clr_i),
            .check  (check),
            .v_ref  (v_p0[0]),
            .v_lane (v_p0[k]),
            .d_ref  (d_ref),
            .d_lane (DW'(lane_slice(1024'(d_p0), k, DW))),
            .mism   (mism[k]),
            .err    (err_o[k]),
            .cnt    (err_cnt_o[k*CW +: CW])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            wcnt  <= '0;
        end else begin
            state <= state_nx;
            wcnt  <= wcnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        wcnt_nx  = wcnt;
        if (!en_i) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (WARMUP == 0) begin
                        state_nx = CHECK;
                    end else begin
                        state_nx = WARM;
                        wcnt_nx  = WLOAD;
                    end
                end
                WARM: begin
                    if (wcnt == '0) state_nx = CHECK;
                    else            wcnt_nx  = wcnt - 1'b1;
                end
                CHECK:   state_nx = CHECK;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Stage p1: cycle count and one-shot capture of the first divergence.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cyc_o        <= '0;
            first_vld_o  <= 1'b0;
            first_mask_o <= '0;
            first_cyc_o  <= '0;
        end else if (check) begin
            cyc_o <= sat_inc16(cyc_o);
            if (!first_vld_o && (|mism)) begin
                first_vld_o  <= 1'b1;
                first_mask_o <= mism;
                first_cyc_o  <= cyc_o;
            end
        end
    end

endmodule

// File: tb/tb_rst_checker.sv
// Randomized plus directed bench for rst_checker against a cycle-level
// behavioural model tracking enabled-run length and per-lane tallies.
module tb_rst_checker;

    localparam int LANES  = 3;
    localparam int DW     = 4;
    localparam int WARMUP = 4;
    localparam int CW     = 8;

    logic                clk = 1'b0;
    logic                rst, en, clr;
    logic [LANES-1:0]    valid;
    logic [LANES*DW-1:0] data;
    logic                armed;
    logic [LANES-1:0]    err;
    logic [LANES*CW-1:0] err_cnt;
    logic [15:0]         cyc;
    logic                first_vld;
    logic [LANES-1:0]    first_mask;
    logic [15:0]         first_cyc;

    always #5 clk = ~clk;

    rst_checker #(
        .LANES(LANES), .DW(DW), .WARMUP(WARMUP), .CW(CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en_i         (en),
        .clr_i        (clr),
        .valid_i      (valid),
        .data_i       (data),
        .armed_o      (armed),
        .err_o        (err),
        .err_cnt_o    (err_cnt),
        .cyc_o        (cyc),
        .first_vld_o  (first_vld),
        .first_mask_o (first_mask),
        .first_cyc_o  (first_cyc)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int              m_run;
    int              m_cyc;
    int              m_cnt [LANES];
    logic [LANES-1:0] m_err;
    logic            m_fv;
    logic [LANES-1:0] m_fmask;
    int              m_fcyc;
    logic [LANES-1:0] pv;
    logic [DW-1:0]   pd [LANES];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [LANES-1:0] mm;
        if (rst) begin
            m_run = 0; m_cyc = 0; m_err = '0; m_fv = 0; m_fmask = '0; m_fcyc = 0;
            for (int k = 0; k < LANES; k++) begin m_cnt[k] = 0; pd[k] = '0; end
            pv = '0;
            return;
        end
        mm = '0;
        for (int k = 1; k < LANES; k++)
            mm[k] = (pv[k] != pv[0]) || (pv[k] && pv[0] && (pd[k] != pd[0]));
        if (clr) begin
            m_cyc = 0; m_err = '0; m_fv = 0; m_fmask = '0; m_fcyc = 0;
            for (int k = 0; k < LANES; k++) m_cnt[k] = 0;
        end else if (m_run >= WARMUP + 1) begin
            for (int k = 1; k < LANES; k++)
                if (mm[k]) begin
                    m_err[k] = 1'b1;
                    if (m_cnt[k] < (1 << CW) - 1) m_cnt[k]++;
                end
            if (mm != 0 && !m_fv) begin
                m_fv = 1; m_fmask = mm; m_fcyc = m_cyc;
            end
            if (m_cyc < 65535) m_cyc++;
        end
        m_run = en ? ((m_run < 1000) ? m_run + 1 : m_run) : 0;
        pv = valid;
        for (int k = 0; k < LANES; k++) pd[k] = data[k*DW +: DW];
    endtask

    task automatic check_all();
        check_val("armed", 32'(armed), 32'(m_run >= WARMUP + 1));
        check_val("err", 32'(err), 32'(m_err));
        for (int k = 0; k < LANES; k++)
            check_val($sformatf("cnt%0d", k), 32'(err_cnt[k*CW +: CW]), 32'(m_cnt[k]));
        check_val("cyc", 32'(cyc), 32'(m_cyc));
        check_val("first_vld", 32'(first_vld), 32'(m_fv));
        check_val("first_mask", 32'(first_mask), 32'(m_fmask));
        check_val("first_cyc", 32'(first_cyc), 32'(m_fcyc));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        rst = 1; en = 0; clr = 0; valid = 3'b111; data = 12'hAAA;
        step(); step();
        check_val("rst_cyc", 32'(cyc), 32'd0);
        check_val("rst_armed", 32'(armed), 32'd0);
        rst = 0;

        // 1: clean run through warm-up
        en = 1;
        repeat (4) step();
        check_val("t1_armed_pre", 32'(armed), 32'd0);
        step();
        check_val("t1_armed_on", 32'(armed), 32'd1);
        repeat (15) step();
        check_val("t1_cyc", 32'(cyc), 32'd15);
        check_val("t1_err", 32'(err), 32'd0);
        check_val("t1_fv", 32'(first_vld), 32'd0);

        // 2: single lane-2 data mismatch captured at cyc 7
        clr = 1; step(); clr = 0;
        for (int i = 0; i < 20 && m_cyc != 6; i++) step();
        data = 12'h5AA; step();
        data = 12'hAAA; step();
        check_val("t2_err", 32'(err), 32'b100);
        check_val("t2_cnt2", 32'(err_cnt[2*CW +: CW]), 32'd1);
        check_val("t2_mask", 32'(first_mask), 32'b100);
        check_val("t2_fcyc", 32'(first_cyc), 32'd7);

        // 3: lane 1 valid stuck low -> saturation
        valid = 3'b101;
        repeat (300) step();
        valid = 3'b111; step(); step();
        check_val("t3_cnt1", 32'(err_cnt[CW +: CW]), 32'd255);
        check_val("t3_err1", 32'(err[1]), 32'd1);
        check_val("t3_cnt2", 32'(err_cnt[2*CW +: CW]), 32'd1);

        // 4: mismatch during warm-up is ignored
        rst = 1; en = 0; step(); rst = 0;
        en = 1; data = 12'hA5A;
        repeat (3) step();
        data = 12'hAAA;
        repeat (4) step();
        data = 12'h55A; step();
        data = 12'hAAA; step(); step();
        check_val("t4_mask", 32'(first_mask), 32'b110);
        check_val("t4_cnt1", 32'(err_cnt[CW +: CW]), 32'd1);

        // 5: clear beats a same-cycle mismatch
        data = 12'h5AA; step();
        data = 12'hAAA; clr = 1; step(); clr = 0;
        check_val("t5_err", 32'(err), 32'd0);
        check_val("t5_cnt2", 32'(err_cnt[2*CW +: CW]), 32'd0);
        check_val("t5_cyc", 32'(cyc), 32'd0);
        check_val("t5_fv", 32'(first_vld), 32'd0);
        check_val("t5_armed", 32'(armed), 32'd1);

        // 6a: reset mid-check
        data = 12'h55A; repeat (3) step();
        data = 12'hAAA; step();
        rst = 1; step(); rst = 0;
        check_val("t6_rst_armed", 32'(armed), 32'd0);
        check_val("t6_rst_cnt", 32'(err_cnt), 32'd0);
        check_val("t6_rst_fv", 32'(first_vld), 32'd0);
        // 6b: enable drop holds counts
        repeat (6) step();
        data = 12'h55A; repeat (2) step();
        data = 12'hAAA; repeat (2) step();
        en = 0; repeat (3) step();
        check_val("t6_en_armed", 32'(armed), 32'd0);
        check_val("t6_en_cnt1", 32'(err_cnt[CW +: CW]), 32'd2);
        check_val("t6_en_cnt2", 32'(err_cnt[2*CW +: CW]), 32'd2);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            logic [3:0] d0;
            rst = ($urandom_range(0, 199) == 0);
            en  = ($urandom_range(0, 15) != 0);
            clr = ($urandom_range(0, 24) == 0);
            valid = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b111;
            d0 = 4'($urandom);
            data[3:0]  = d0;
            data[7:4]  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : d0;
            data[11:8] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : d0;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rst_checker.md
Name: rst_checker

Overview:
Downstream consumer of the three-lane reset-strategy comparison wrapper. It takes the registered per-lane valid/data outputs and treats lane 0 (full-reset lane) as golden. Each other lane is compared against lane 0 every cycle after a programmable warm-up window. Mismatches are counted per lane, and the first divergence is captured so reset-strategy differences are observable on hardware and in sim.

Parameters:
LANES, 3, number of lanes; lane 0 is golden; must be >= 2
DW, 4, data width per lane
WARMUP, 4, cycles after enable during which comparisons are ignored (0 = none)
CW, 8, width of each per-lane mismatch counter (saturating)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
en_i  in  1  enable checking; low returns FSM to IDLE
clr_i  in  1  clear counters/flags/capture; FSM state unaffected
valid_i  in  LANES  per-lane valid, bit k = lane k
data_i  in  LANES*DW  lane k at [k*DW +: DW]
armed_o  out  1  high while FSM in CHECK
err_o  out  LANES  sticky per-lane mismatch flag; bit 0 always 0
err_cnt_o  out  LANES*CW  per-lane mismatch count, lane k at [k*CW +: CW]; lane 0 field always 0
cyc_o  out  16  number of CHECK cycles evaluated, saturating at 16'hFFFF
first_vld_o  out  1  a first mismatch has been captured
first_mask_o  out  LANES  lanes mismatching on the captured cycle
first_cyc_o  out  16  cyc_o value at the captured cycle

Behaviour:
- Reset is synchronous, active-high, and single-clock. All outputs, input pipeline regs, the warm-up counter and the FSM (state IDLE) reset to 0.
- rst asserted mid-operation: everything returns to reset values on that edge, regardless of state.
- Input stage: valid_i and data_i are registered unconditionally into v_r and d_r. Compare is done on v_r/d_r.
- Mismatch on lane k (k >= 1) on a cycle:
  - v_r[k] != v_r[0], or
  - v_r[k] = v_r[0] = 1 and d_r lane k != d_r lane 0.
  - Data is ignored when both valids are 0.
- Latency: inputs sampled at edge N are reflected in err_o, err_cnt_o and cyc_o after edge N+1.
- FSM states and transitions:
  - IDLE: when en_i=1, go to WARM and load warm-up counter = WARMUP-1. If WARMUP=0, go directly to CHECK.
  - WARM: decrement each cycle; when counter = 0, go to CHECK on the next edge. No compares in WARM.
  - CHECK: armed_o=1. Each cycle, cyc_o increments (saturating) and the compare result is applied.
  - Any state: en_i=0 -> IDLE on the next edge. Counters, flags and capture hold their values.
- Per-lane mismatch in CHECK:
  - err_o[k] is set and stays set.
  - err_cnt_o lane k increments, saturating at 2^CW-1.
- First capture: on the first CHECK cycle with any mismatch while first_vld_o=0:
  - first_vld_o=1;
  - first_mask_o = mismatch vector;
  - first_cyc_o = cyc_o value before increment.
  - Later mismatches do not overwrite the capture.
- clr_i: on the next edge, clears err_o, err_cnt_o, cyc_o and all first_* outputs.
  - clr_i wins over a same-cycle mismatch or cyc increment; that cycle is not counted.
- en_i rising while clr_i=1: the state transition proceeds as normal and the clear also takes effect.
- Width rules: all counters are unsigned and saturate, never wrap. Lane 0 fields are tied to 0.

Decomposition:
- Shared package holds: FSM state enum (IDLE, WARM, CHECK), default LANES/DW/CW constants, and a lane-slice helper function.
- One sub-module, rst_checker_lane: per-lane compare, sticky flag and saturating counter, instantiated for lanes 1..LANES-1.
- FSM, cycle counter and first capture stay in the top module.

Test Plan:
1. Reset, en_i=1 with WARMUP=4, all lanes identical (valid=3'b111, data=12'hAAA) for 20 cycles -> armed_o rises 5 cycles after the en_i edge; cyc_o counts to the number of CHECK cycles; err_o=0; first_vld_o=0.
2. In CHECK at cyc_o=7, drive lane 2 data=4'h5 vs lane 0 data=4'hA for one cycle -> err_o=3'b100, lane 2 count=1, first_mask_o=3'b100, first_cyc_o=7.
3. Lane 1 valid=0 while lane 0 valid=1 for 300 cycles (CW=8) -> lane 1 count saturates at 255; err_o[1]=1; lane 2 count unchanged.
4. Mismatch on lane 1 during WARM, then a mismatch on both lanes in CHECK -> the WARM mismatch is ignored; first_mask_o=3'b110.
5. clr_i asserted on the same cycle as a lane 2 mismatch -> all counters, flags and capture are 0 afterwards; armed_o stays 1.
6. rst pulsed mid-CHECK with nonzero counts, and en_i dropped in a separate run -> rst: all outputs 0 and FSM in IDLE; en_i drop: armed_o=0 and counts held.
